// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer in front of a weight-stationary systolic array. It collects
//   ARRAY_SIZE weight rows over a valid/ready stream and shifts them into the
//   array. It then streams the job's activation vectors with a per-lane skew
//   (lane i lags lane 0 by i cycles) and drains the array. Output rows that
//   carry real results are flagged, and the end of the job is signalled with a
//   one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   start        begin a job (sampled only while idle)
//   num_vecs     activation vectors in the job, latched on start
//   w_valid/w_ready/w_data   weight row stream
//   a_valid/a_ready/a_data   activation vector stream, lane i = [i*DW +: DW]
//   load         array weight shift enable
//   weights      weight row presented to the array
//   activations  skewed activation lanes presented to the array
//   out_valid    array output row holds a real result this cycle
//   busy         job in progress
//   done         one-cycle pulse at job end
// ---------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 4,
  parameter int PIPE_LAT   = 8,
  parameter int CNT_W      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 num_vecs,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  output logic                             load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int WC_W      = $clog2(ARRAY_SIZE) + 1;
  localparam int DRAIN_CYC = PIPE_LAT + ARRAY_SIZE - 1;
  localparam int DC_W      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [WC_W-1:0]  w_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [DC_W-1:0]  drain_cnt;

  logic w_acc;
  logic a_acc;

  // Handshakes depend only on state and counters, never on the valids.
  assign w_ready = (state == S_LOAD);
  assign a_ready = (state == S_FEED) && (v_cnt < num_lat);
  assign w_acc   = w_valid & w_ready;
  assign a_acc   = a_valid & a_ready;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      num_lat   <= '0;
      w_cnt     <= '0;
      v_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_lat   <= num_vecs;
            w_cnt     <= '0;
            v_cnt     <= '0;
            drain_cnt <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          // w_cnt has one spare bit so it can reach ARRAY_SIZE.
          if (w_acc) begin
            w_cnt <= w_cnt + 1'b1;
            if (w_cnt == WC_W'(ARRAY_SIZE - 1)) begin
              state <= (num_lat == '0) ? S_DRAIN : S_FEED;
            end
          end
        end
        S_FEED: begin
          // a_ready guarantees num_lat >= 1 here, so num_lat-1 cannot wrap,
          // and v_cnt tops out at num_lat, which fits CNT_W.
          if (a_acc) begin
            v_cnt <= v_cnt + 1'b1;
            if (v_cnt == num_lat - CNT_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Long enough for the last vector to leave the deepest skew lane
          // and pass through the array.
          if (drain_cnt == DC_W'(DRAIN_CYC - 1)) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p0: weight row register. Bubbles present load=0 and a zero row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load    <= 1'b0;
      weights <= '0;
    end else begin
      load    <= w_acc;
      weights <= w_acc ? w_data : '0;
    end
  end

  // Stage p0..pN: skew lines. Lane i holds i+1 registers, so lane 0 appears
  // one cycle after the accept and each further lane one cycle later.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] dly_p [0:i];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s <= i; s++) dly_p[s] <= '0;
      end else begin
        dly_p[0] <= a_acc ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) dly_p[s] <= dly_p[s-1];
      end
    end

    assign activations[i*DATA_WIDTH +: DATA_WIDTH] = dly_p[i];
  end

  // Stage p0 valid: high while a real vector sits on lane 0 of activations.
  logic                vld_p0;
  logic [PIPE_LAT-1:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_p0   <= a_acc;
      vld_pipe <= {vld_pipe[PIPE_LAT-2:0], vld_p0};
    end
  end

  // Stage p0+PIPE_LAT: matches the array latency from lane 0 to output_row.
  assign out_valid = vld_pipe[PIPE_LAT-1];

endmodule
